// File: rtl/posix_time_pkg.sv
// Shared constants, FSM encoding and seconds-of-day helper for the POSIX time-set path.
// Pure package: no timing of its own.
// No flow control; consumed by time_to_posix_time and its divider.
package posix_time_pkg;

  localparam int SEC_IN_MIN  = 60;
  localparam int MIN_IN_HOUR = 60;
  localparam int HOUR_IN_DAY = 24;
  localparam int SEC_IN_HOUR = SEC_IN_MIN * MIN_IN_HOUR;
  localparam int SEC_IN_DAY  = SEC_IN_HOUR * HOUR_IN_DAY;

  localparam int HOUR_W = 5;
  localparam int MIN_W  = 6;
  localparam int SEC_W  = 6;
  localparam int SOD_W  = 17;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // h*3600 + m*60 + s using shifts only: 3600 = 2048+1024+512+16, 60 = 64-4.
  function automatic logic [SOD_W-1:0] sod_calc(input logic [HOUR_W-1:0] h,
                                                input logic [MIN_W-1:0]  m,
                                                input logic [SEC_W-1:0]  s);
    logic [SOD_W-1:0] hh;
    logic [SOD_W-1:0] mm;
    logic [SOD_W-1:0] ss;
    hh = SOD_W'(h);
    mm = SOD_W'(m);
    ss = SOD_W'(s);
    return (hh << 11) + (hh << 10) + (hh << 9) + (hh << 4)
         + (mm << 6) - (mm << 2) + ss;
  endfunction

endpackage

// File: rtl/time_to_posix_time_seq_const_mod.sv
// Sequential restoring remainder of a W-bit dividend by a constant, one bit per cycle.
// Latency W cycles after start; done_o marks the cycle of the final step.
// No backpressure: start is honoured at any time and restarts the operation.
module seq_const_mod #(
  parameter int W     = 32,
  parameter int DIV   = 86400,
  parameter int REM_W = 18
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
  input  logic [W-1:0]     dividend_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [REM_W-1:0] rem_o
);

  localparam int CNT_W = $clog2(W) + 1;
  localparam logic [REM_W-1:0] DIV_V = REM_W'(DIV);

  logic [W-1:0]     dvd_q, dvd_d;
  logic [REM_W-1:0] rem_q, rem_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic [REM_W-1:0] trial;

  // Shift the next dividend bit into the partial remainder; subtract when it fits.
  always_comb begin
    dvd_d  = dvd_q;
    rem_d  = rem_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    trial  = {rem_q[REM_W-2:0], dvd_q[W-1]};
    if (start_i) begin
      dvd_d  = dividend_i;
      rem_d  = '0;
      cnt_d  = CNT_W'(W - 1);
      busy_d = 1'b1;
    end else if (busy_q) begin
      dvd_d = {dvd_q[W-2:0], 1'b0};
      rem_d = (trial >= DIV_V) ? (trial - DIV_V) : trial;
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == '0) begin
        busy_d = 1'b0;
      end
    end
  end

  // Divider state registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      dvd_q  <= '0;
      rem_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      dvd_q  <= dvd_d;
      rem_q  <= rem_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  assign busy_o = busy_q;
  assign done_o = busy_q && (cnt_q == '0);
  assign rem_o  = rem_q;

endmodule

// File: rtl/time_to_posix_time.sv
// Converts a requested local hh:mm:ss into the POSIX second count on the current local day.
// Latency: valid_o pulses 33 edges after the accepting edge; one request per 34 cycles.
// ready_o is low while a conversion is in flight; valid_i is ignored then.
module time_to_posix_time
  import posix_time_pkg::*;
#(
  parameter int GMT = 3
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [31:0]       cur_posix_i,
  input  logic [HOUR_W-1:0] hour_i,
  input  logic [MIN_W-1:0]  min_i,
  input  logic [SEC_W-1:0]  sec_i,
  input  logic              valid_i,
  output logic              ready_o,
  output logic [31:0]       posix_time_o,
  output logic              valid_o,
  output logic              err_o
);

  // Negative offsets wrap to their two's-complement value.
  localparam logic [31:0] GMT_OFS = 32'(GMT * SEC_IN_HOUR);

  state_t           state_q, state_d;
  logic [31:0]      cur_q;
  logic [SOD_W-1:0] sod_new_q;
  logic [31:0]      posix_q;
  logic             valid_q;
  logic             err_q;

  logic             accept;
  logic             bad_req;
  logic             start;
  logic             mod_busy;
  logic             mod_done;
  logic [17:0]      sod_cur;

  assign bad_req = (hour_i > HOUR_W'(HOUR_IN_DAY - 1)) ||
                   (min_i  > MIN_W'(MIN_IN_HOUR - 1))  ||
                   (sec_i  > SEC_W'(SEC_IN_MIN - 1));
  assign ready_o = (state_q == IDLE) && !mod_busy;
  assign accept  = valid_i && ready_o;
  assign start   = accept && !bad_req;

  // The divider latches local time x = cur + offset itself on start.
  seq_const_mod #(
    .W    (32),
    .DIV  (SEC_IN_DAY),
    .REM_W(18)
  ) u_mod (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .start_i   (start),
    .dividend_i(cur_posix_i + GMT_OFS),
    .busy_o    (mod_busy),
    .done_o    (mod_done),
    .rem_o     (sod_cur)
  );

  // Next-state logic: run the divider, then spend one cycle forming the result.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start)    state_d = CALC;
      CALC:    if (mod_done) state_d = DONE;
      DONE:                  state_d = IDLE;
      default:               state_d = IDLE;
    endcase
  end

  // State, request capture and result registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= IDLE;
      cur_q     <= '0;
      sod_new_q <= '0;
      posix_q   <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= accept && bad_req;
      valid_q <= (state_q == DONE);
      if (start) begin
        cur_q     <= cur_posix_i;
        sod_new_q <= sod_calc(hour_i, min_i, sec_i);
      end
      if (state_q == DONE) begin
        posix_q <= cur_q - 32'(sod_cur) + 32'(sod_new_q);
      end
    end
  end

  assign posix_time_o = posix_q;
  assign valid_o      = valid_q;
  assign err_o        = err_q;

endmodule
